// File: rtl/target_hit_timer_pkg.sv
// Shared constants for the target-hit reaction timer: game FSM states,
// default timing parameters and target-code helpers.
package target_hit_timer_pkg;

    localparam int unsigned TICK_DIV_DEF        = 50000;
    localparam int unsigned DEBOUNCE_CYCLES_DEF = 250000;
    localparam int unsigned GAME_SECONDS_DEF    = 60;
    localparam int unsigned MS_PER_SEC_DEF      = 1000;

    localparam int unsigned N_SENSORS = 8;
    localparam int unsigned N_INPUTS  = N_SENSORS + 1;
    localparam int unsigned BTN_IDX   = N_SENSORS;
    localparam int unsigned N_PLAYERS = 2;

    localparam logic [3:0] CODE_NONE = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_OVER = 2'd2
    } game_state_e;

    // Codes 8-15 mean "no active target" for that player.
    function automatic logic code_valid(input logic [3:0] code);
        return ~code[3];
    endfunction

endpackage

// File: rtl/target_hit_timer_input_debounce.sv
// Two-flop synchronizer, stability-count debouncer and registered
// rising-edge pulse for one asynchronous, bouncy input.
module input_debounce
    import target_hit_timer_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic raw_i,
    output logic level_o,
    output logic rise_o
);

    localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q, sync2_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d;
    logic          level_dly_q;
    logic          rise_q, rise_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            cnt_q       <= '0;
            level_q     <= 1'b0;
            level_dly_q <= 1'b0;
            rise_q      <= 1'b0;
        end else begin
            sync1_q     <= raw_i;
            sync2_q     <= sync1_q;
            cnt_q       <= cnt_d;
            level_q     <= level_d;
            level_dly_q <= level_q;
            rise_q      <= rise_d;
        end
    end

    // The counter restarts whenever the synced value agrees with the accepted level.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
        rise_d = level_q & ~level_dly_q;
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;

endmodule

// File: rtl/target_hit_timer.sv
// Two-player reaction timer: debounced sensors/button, ms/second tick
// generation, game countdown FSM and per-player hit flag and ms timer.
module target_hit_timer
    import target_hit_timer_pkg::*;
#(
    parameter int unsigned TICK_DIV        = TICK_DIV_DEF,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int unsigned GAME_SECONDS    = GAME_SECONDS_DEF,
    parameter int unsigned MS_PER_SEC      = MS_PER_SEC_DEF
) (
    input  logic        clock,
    input  logic        ctrl_reset_n,
    input  logic [7:0]  sensor_raw,
    input  logic        button_raw,
    input  logic [31:0] t1active_read,
    input  logic [31:0] t2active_read,
    output logic [31:0] bp_write,
    output logic [31:0] t1hit_write,
    output logic [31:0] t2hit_write,
    output logic [31:0] timer1_write,
    output logic [31:0] timer2_write,
    output logic [31:0] gametimer_write,
    output logic [1:0]  game_state
);

    localparam int unsigned TCW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned SCW = (MS_PER_SEC > 1) ? $clog2(MS_PER_SEC) : 1;
    localparam logic [TCW-1:0] TICK_LAST = TCW'(TICK_DIV - 1);
    localparam logic [SCW-1:0] SEC_LAST  = SCW'(MS_PER_SEC - 1);
    localparam logic [31:0]    GAME_LOAD = 32'(GAME_SECONDS);

    logic [N_INPUTS-1:0] raw_in, level, rise;
    logic                btn_rise;

    assign raw_in   = {button_raw, sensor_raw};
    assign btn_rise = rise[BTN_IDX];

    for (genvar g = 0; g < N_INPUTS; g++) begin : g_deb
        input_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .clk_i  (clock),
            .rst_ni (ctrl_reset_n),
            .raw_i  (raw_in[g]),
            .level_o(level[g]),
            .rise_o (rise[g])
        );
    end

    logic [TCW-1:0] presc_q, presc_d;
    logic [SCW-1:0] sec_q, sec_d;
    logic           ms_tick, sec_tick;

    game_state_e    state_q, state_d;
    logic [31:0]    gt_q, gt_d;
    logic           start, enter_idle;

    logic [N_PLAYERS-1:0][3:0]  code_q, code_d, active_code;
    logic [N_PLAYERS-1:0]       hit_q, hit_d;
    logic [N_PLAYERS-1:0][31:0] timer_q, timer_d;

    assign active_code = {t2active_read[3:0], t1active_read[3:0]};

    logic unused_code_bits;
    assign unused_code_bits = ^{t1active_read[31:4], t2active_read[31:4]};

    assign ms_tick  = (presc_q == TICK_LAST);
    assign sec_tick = ms_tick && (sec_q == SEC_LAST);

    always_comb begin
        presc_d = ms_tick ? '0 : presc_q + TCW'(1);
        sec_d   = sec_q;
        if (start) begin
            sec_d = '0;
        end else if (ms_tick) begin
            sec_d = sec_tick ? '0 : sec_q + SCW'(1);
        end
    end

    always_comb begin
        state_d    = state_q;
        gt_d       = gt_q;
        start      = 1'b0;
        enter_idle = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (btn_rise) begin
                    state_d = ST_RUN;
                    gt_d    = GAME_LOAD;
                    start   = 1'b1;
                end
            end
            ST_RUN: begin
                if (sec_tick) begin
                    if (gt_q == 32'd1) begin
                        state_d = ST_OVER;
                        gt_d    = '0;
                    end else if (gt_q != '0) begin
                        gt_d = gt_q - 32'd1;
                    end
                end
            end
            ST_OVER: begin
                if (btn_rise) begin
                    state_d    = ST_IDLE;
                    enter_idle = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // A code change wins over a same-cycle sensor edge for that player.
    always_comb begin
        code_d  = active_code;
        hit_d   = hit_q;
        timer_d = timer_q;
        for (int unsigned p = 0; p < N_PLAYERS; p++) begin
            if (enter_idle || (active_code[p] != code_q[p])) begin
                hit_d[p]   = 1'b0;
                timer_d[p] = '0;
            end else if ((state_q == ST_RUN) && code_valid(code_q[p]) && !hit_q[p]) begin
                if (ms_tick && (timer_q[p] != '1)) begin
                    timer_d[p] = timer_q[p] + 32'd1;
                end
                if (rise[code_q[p][2:0]]) begin
                    hit_d[p] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            presc_q <= '0;
            sec_q   <= '0;
            state_q <= ST_IDLE;
            gt_q    <= '0;
            code_q  <= {N_PLAYERS{CODE_NONE}};
            hit_q   <= '0;
            timer_q <= '0;
        end else begin
            presc_q <= presc_d;
            sec_q   <= sec_d;
            state_q <= state_d;
            gt_q    <= gt_d;
            code_q  <= code_d;
            hit_q   <= hit_d;
            timer_q <= timer_d;
        end
    end

    assign bp_write        = {31'b0, level[BTN_IDX]};
    assign t1hit_write     = {31'b0, hit_q[0]};
    assign t2hit_write     = {31'b0, hit_q[1]};
    assign timer1_write    = timer_q[0];
    assign timer2_write    = timer_q[1];
    assign gametimer_write = gt_q;
    assign game_state      = state_q;

endmodule

// File: doc/target_hit_timer.md
TARGET_HIT_TIMER -- requirements
Module: target_hit_timer

Interface
REQ-001 Parameter TICK_DIV, 50000, clock cycles per 1 ms tick (50 MHz clock).
REQ-002 Parameter DEBOUNCE_CYCLES, 250000, consecutive stable cycles before a synced input level is accepted.
REQ-003 Parameter GAME_SECONDS, 60, game length loaded at start.
REQ-004 clock  in  1  sole clock; all state on posedge.
REQ-005 ctrl_reset_n  in  1  asynchronous, active-low reset.
REQ-006 sensor_raw  in  8  asynchronous target hit sensors, active-high, bouncy.
REQ-007 button_raw  in  1  asynchronous start button, active-high, bouncy.
REQ-008 t1active_read, t2active_read  in  32 each  active-target codes from register file; [3:0] 0-7 = target index, 8-15 = no target.
REQ-009 bp_write  out  32  {31'b0, debounced button level}.
REQ-010 t1hit_write, t2hit_write  out  32 each  {31'b0, player hit flag}.
REQ-011 timer1_write, timer2_write  out  32 each  ms elapsed since player's target was activated.
REQ-012 gametimer_write  out  32  seconds remaining in game.
REQ-013 game_state  out  2  IDLE=0, RUN=1, OVER=2.

Function
REQ-014 Each of 9 raw inputs SHALL pass a 2-flop synchronizer then debouncer; debounced level changes only after DEBOUNCE_CYCLES consecutive cycles of a new synced value.
REQ-015 Rising edge of a debounced signal SHALL be a one-cycle pulse, cycle after debounced level rises.
REQ-016 A free-running prescaler SHALL emit a 1-cycle ms_tick every TICK_DIV cycles, counting 0..TICK_DIV-1 and wrapping; a second counter emits sec_tick every 1000 ms_ticks, cleared on IDLE->RUN.
REQ-017 FSM: IDLE --button edge--> RUN (gametimer loaded GAME_SECONDS); RUN --sec_tick with gametimer==1--> OVER (gametimer=0); OVER --button edge--> IDLE; other transitions none.
REQ-018 In RUN, gametimer SHALL decrement by 1 per sec_tick, never below 0.
REQ-019 Player n code valid when code[3]==0; block SHALL register code[3:0] each cycle and flag code_change when current differs from registered.
REQ-020 On code_change: hit_n cleared and timer_n zeroed next cycle; a sensor edge in the same cycle is ignored for that player.
REQ-021 hit_n SHALL set when state==RUN, code valid, no code_change, and edge pulse on sensor[code[2:0]]; once set it holds until code_change or leaving RUN.
REQ-022 timer_n SHALL increment on ms_tick only when RUN, code valid, hit_n==0; it freezes on hit and saturates at 32'hFFFF_FFFF.
REQ-023 Players SHALL be evaluated independently; simultaneous edges on both players' sensors set both flags same cycle.
REQ-024 Entering IDLE SHALL clear hit flags and timers; entering OVER freezes them.
REQ-025 All outputs SHALL be registered; no combinational path input-to-output.

Reset
REQ-026 ctrl_reset_n low SHALL immediately force: state IDLE, all outputs 0, synchronizers/debouncers/prescalers 0, registered codes 4'hF.
REQ-027 Reset asserted mid-game SHALL abort RUN with no residual hit, timer or tick state after release.
REQ-028 First ms_tick after release SHALL occur TICK_DIV cycles after first clock edge with ctrl_reset_n high.

Structure
REQ-029 FSM state encodings and default parameter values SHALL live in the shared project package/header.
REQ-030 One sub-module, input_debounce (synchronizer + debounce counter + edge pulse), instanced 9 times.

Verification (TICK_DIV=4, DEBOUNCE_CYCLES=3, GAME_SECONDS=2, ms-per-sec reduced to 5 via bench override)
REQ-031 Button pulse 10 cycles from IDLE -> game_state=1, gametimer_write=2; after 2 sec_ticks -> game_state=2, gametimer_write=0.
REQ-032 Button glitch 2 cycles -> bp_write stays 0, game_state stays 0.
REQ-033 RUN, t1active=3, sensor_raw[3] high 10 cycles after 5 ms_ticks -> t1hit_write=1, timer1_write frozen at 5.
REQ-034 Hit set, t1active changes 3->6 -> next cycle t1hit_write=0, timer1_write=0; sensor[3] edge same cycle ignored.
REQ-035 t1active=2, t2active=5, sensor_raw[2] and [5] rise same cycle -> both hit flags 1 same cycle.
REQ-036 ctrl_reset_n low mid-RUN with timers nonzero -> all outputs 0 immediately, game_state=0 after release.
